// File: rtl/queue_writer.sv
// queue_writer: open-list RAM write manager (insert/remove/clear); QUEUE_WRITER_STATS_EN adds peak/discard stats
module queue_writer #(
  parameter int MAX_NODES = 100,
  parameter int ENTRY_W = 272
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_insert,
  input  logic               op_remove,
  input  logic               op_clear,
  input  logic [ENTRY_W-1:0] cand_node,
  input  logic               child_queued,
  input  logic [6:0]         child_address,
  input  logic [ENTRY_W-1:0] child_from_queue,
  input  logic [6:0]         remove_address,
  input  logic [ENTRY_W-1:0] ram_read_data,
  output logic [6:0]         ram_read_address,
  output logic               ram_write_enable,
  output logic [6:0]         ram_write_address,
  output logic [ENTRY_W-1:0] ram_write_data,
  output logic               busy,
  output logic               done,
  output logic [1:0]         result,
  output logic [6:0]         queue_count,
  output logic               queue_empty,
  output logic               queue_full,
  output logic [6:0]         peak_count,
  output logic [15:0]        discard_count
);
  typedef enum logic [3:0] {IDLE, INS_DECIDE, INS_WRITE, REM_READ, REM_WAIT, REM_MOVE, REM_ZERO, CLR, FINISH} state_t;
  localparam logic [6:0] LAST = 7'(MAX_NODES - 1);
  state_t state, state_n;
  logic [ENTRY_W-1:0] cand_q;
  logic queued_q;
  logic [6:0] caddr_q, raddr_q, count, count_n, clr_addr, clr_addr_n;
  logic [15:0] qcost_q;
  logic [1:0] res, res_n;
  // state, counters and operand latches; operands track inputs while idle so they hold the accept-cycle values
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      clr_addr <= '0;
      res <= '0;
      cand_q <= '0;
      queued_q <= 1'b0;
      caddr_q <= '0;
      raddr_q <= '0;
      qcost_q <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      clr_addr <= clr_addr_n;
      res <= res_n;
      if (state == IDLE) begin
        cand_q <= cand_node;
        queued_q <= child_queued;
        caddr_q <= child_address;
        raddr_q <= remove_address;
        qcost_q <= child_from_queue[207:192];
      end
    end
  end
  // next-state, bookkeeping and the single RAM write port
  always_comb begin
    state_n = state;
    count_n = count;
    res_n = res;
    clr_addr_n = clr_addr;
    ram_write_enable = 1'b0;
    ram_write_address = '0;
    ram_write_data = '0;
    case (state)
      IDLE:
        if (op_clear) begin
          state_n = CLR;
          clr_addr_n = '0;
          count_n = '0;
          res_n = 2'b00;
        end else if (op_remove) begin
          res_n = (count == 7'd0 || remove_address >= count) ? 2'b11 : 2'b00;
          state_n = (count == 7'd0 || remove_address >= count) ? FINISH :
                    (remove_address == count - 7'd1) ? REM_ZERO : REM_READ;
        end else if (op_insert) state_n = INS_DECIDE;
      INS_DECIDE: begin
        res_n = queued_q ? ((cand_q[207:192] < qcost_q) ? 2'b01 : 2'b10) : (queue_full ? 2'b11 : 2'b00);
        state_n = (res_n[1]) ? FINISH : INS_WRITE;
      end
      INS_WRITE: begin
        ram_write_enable = 1'b1;
        ram_write_address = (res == 2'b01) ? caddr_q : count;
        ram_write_data = cand_q;
        count_n = (res == 2'b00) ? count + 7'd1 : count;
        state_n = FINISH;
      end
      REM_READ: state_n = REM_WAIT;
      REM_WAIT: state_n = REM_MOVE;
      REM_MOVE: begin
        ram_write_enable = 1'b1;
        ram_write_address = raddr_q;
        ram_write_data = ram_read_data;
        state_n = REM_ZERO;
      end
      REM_ZERO: begin
        ram_write_enable = 1'b1;
        ram_write_address = count - 7'd1;
        count_n = count - 7'd1;
        state_n = FINISH;
      end
      CLR: begin
        ram_write_enable = 1'b1;
        ram_write_address = clr_addr;
        clr_addr_n = clr_addr + 7'd1;
        state_n = (clr_addr == LAST) ? FINISH : CLR;
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign ram_read_address = (state == REM_READ || state == REM_WAIT || state == REM_MOVE) ? count - 7'd1 : '0;
  assign busy = state != IDLE;
  assign done = state == FINISH;
  assign result = res;
  assign queue_count = count;
  assign queue_empty = count == 7'd0;
  assign queue_full = count == 7'(MAX_NODES);
`ifdef QUEUE_WRITER_STATS_EN
  logic [6:0] peak;
  logic [15:0] disc;
  // high-water mark and saturating count of rejected inserts, both cleared by reset or clear
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE && op_clear)) begin
      peak <= '0;
      disc <= '0;
    end else begin
      if (count_n > peak) peak <= count_n;
      if (state == INS_DECIDE && res_n[1] && disc != 16'hFFFF) disc <= disc + 16'd1;
    end
  end
  assign peak_count = peak;
  assign discard_count = disc;
`else
  assign peak_count = '0;
  assign discard_count = '0;
`endif
endmodule

// File: tb/tb_queue_writer.sv
// tb_queue_writer: scoreboard bench for queue_writer with a behavioural queue RAM
module tb_queue_writer;
`ifdef QUEUE_WRITER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, op_insert = 1'b0, op_remove = 1'b0, op_clear = 1'b0;
  logic [271:0] cand_node = '0, child_from_queue = '0, ram_read_data, ram_write_data;
  logic child_queued = 1'b0;
  logic [6:0] child_address = '0, remove_address = '0;
  logic [6:0] ram_read_address, ram_write_address, queue_count, peak_count;
  logic ram_write_enable, busy, done, queue_empty, queue_full;
  logic [1:0] result;
  logic [15:0] discard_count;
  logic [271:0] mem [0:127];
  typedef struct {logic [6:0] a; logic [271:0] d;} wr_t;
  wr_t exp_q[$];
  int tests = 0, failed = 0;

  queue_writer dut (
    .clk(clk), .reset(reset), .op_insert(op_insert), .op_remove(op_remove), .op_clear(op_clear),
    .cand_node(cand_node), .child_queued(child_queued), .child_address(child_address),
    .child_from_queue(child_from_queue), .remove_address(remove_address), .ram_read_data(ram_read_data),
    .ram_read_address(ram_read_address), .ram_write_enable(ram_write_enable),
    .ram_write_address(ram_write_address), .ram_write_data(ram_write_data), .busy(busy), .done(done),
    .result(result), .queue_count(queue_count), .queue_empty(queue_empty), .queue_full(queue_full),
    .peak_count(peak_count), .discard_count(discard_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_write_address] <= ram_write_data;
    ram_read_data <= mem[ram_read_address];
  end

  task automatic check(input string tag, input logic [271:0] got, input logic [271:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ram_write_enable) begin
      if (exp_q.size() == 0) check("unexp_wr", ram_write_enable, 1'b0);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", ram_write_address, e.a);
        check("wr_data", ram_write_data, e.d);
      end
    end
  end

  function automatic logic [271:0] mk(input logic [15:0] id, input logic [15:0] cost);
    mk = '0;
    mk[239:224] = id;
    mk[207:192] = cost;
    mk[15:0] = ~id;
    mk[271:256] = cost ^ 16'h5A5A;
  endfunction

  task automatic push(input logic [6:0] a, input logic [271:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic run(input string tag, input int lat, input logic [1:0] res_e, input logic [6:0] cnt_e);
    int n = 0;
    @(posedge clk);
    #1 {op_insert, op_remove, op_clear} = 3'b000;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_res"}, result, res_e);
    check({tag, "_cnt"}, queue_count, cnt_e);
    check({tag, "_sb"}, exp_q.size(), 0);
  endtask

  task automatic ins(input string tag, input logic [271:0] c, input logic q, input logic [6:0] ca,
                     input logic [15:0] qcost, input bit wr, input logic [6:0] wa,
                     input int lat, input logic [1:0] res_e, input logic [6:0] cnt_e);
    @(negedge clk);
    if (wr) push(wa, c);
    cand_node = c;
    child_queued = q;
    child_address = ca;
    child_from_queue = mk(16'd0, qcost);
    op_insert = 1'b1;
    run(tag, lat, res_e, cnt_e);
  endtask

  task automatic rem(input string tag, input logic [6:0] ra, input int lat, input logic [1:0] res_e, input logic [6:0] cnt_e);
    @(negedge clk);
    remove_address = ra;
    op_remove = 1'b1;
    run(tag, lat, res_e, cnt_e);
  endtask

  task automatic clr();
    @(negedge clk);
    for (int i = 0; i < 100; i++) push(7'(i), '0);
    op_clear = 1'b1;
    run("clear", 101, 2'b00, 7'd0);
    check("clear_empty", queue_empty, 1'b1);
    check("clear_peak", peak_count, 7'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_we", ram_write_enable, 1'b0);
    check("rst_cnt", queue_count, 7'd0);
    check("rst_empty", queue_empty, 1'b1);
    check("rst_res", result, 2'b00);
    reset = 1'b0;
    clr();
    ins("app5", mk(16'd5, 16'd40), 1'b0, 7'd0, 16'd0, 1'b1, 7'd0, 3, 2'b00, 7'd1);
    ins("upd30", mk(16'd5, 16'd30), 1'b1, 7'd0, 16'd40, 1'b1, 7'd0, 3, 2'b01, 7'd1);
    ins("disc50", mk(16'd5, 16'd50), 1'b1, 7'd0, 16'd30, 1'b0, 7'd0, 2, 2'b10, 7'd1);
    check("disc_cnt1", discard_count, STATS ? 16'd1 : 16'd0);
    ins("disc_eq", mk(16'd5, 16'd30), 1'b1, 7'd0, 16'd30, 1'b0, 7'd0, 2, 2'b10, 7'd1);
    ins("upd_uns", mk(16'd5, 16'd1), 1'b1, 7'd0, 16'h8000, 1'b1, 7'd0, 3, 2'b01, 7'd1);
    ins("app6", mk(16'd6, 16'd60), 1'b0, 7'd0, 16'd0, 1'b1, 7'd1, 3, 2'b00, 7'd2);
    ins("app7", mk(16'd7, 16'd70), 1'b0, 7'd0, 16'd0, 1'b1, 7'd2, 3, 2'b00, 7'd3);
    check("peak3", peak_count, STATS ? 7'd3 : 7'd0);
    push(7'd0, mk(16'd7, 16'd70));
    push(7'd2, '0);
    rem("rem_mv", 7'd0, 5, 2'b00, 7'd2);
    rem("rem_bad9", 7'd9, 1, 2'b11, 7'd2);
    rem("rem_eqcnt", 7'd2, 1, 2'b11, 7'd2);
    push(7'd1, '0);
    rem("rem_last", 7'd1, 2, 2'b00, 7'd1);
    for (int i = 1; i < 100; i++)
      ins("fill", mk(16'(100 + i), 16'(i)), 1'b0, 7'd0, 16'd0, 1'b1, 7'(i), 3, 2'b00, 7'(i + 1));
    check("full", queue_full, 1'b1);
    ins("ins_full", mk(16'd999, 16'd1), 1'b0, 7'd0, 16'd0, 1'b0, 7'd0, 2, 2'b11, 7'd100);
    check("full_hold", queue_full, 1'b1);
    check("disc_cnt3", discard_count, STATS ? 16'd3 : 16'd0);
    check("peak100", peak_count, STATS ? 7'd100 : 7'd0);
    clr();
    check("clear_disc", discard_count, 16'd0);
    rem("rem_empty", 7'd0, 1, 2'b11, 7'd0);
    ins("appA", mk(16'd20, 16'd2), 1'b0, 7'd0, 16'd0, 1'b1, 7'd0, 3, 2'b00, 7'd1);
    ins("appB", mk(16'd21, 16'd3), 1'b0, 7'd0, 16'd0, 1'b1, 7'd1, 3, 2'b00, 7'd2);
    @(negedge clk);
    push(7'd0, mk(16'd21, 16'd3));
    remove_address = 7'd0;
    op_remove = 1'b1;
    @(posedge clk);
    #1 op_remove = 1'b0;
    repeat (3) @(negedge clk);
    check("mv_we", ram_write_enable, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_cnt", queue_count, 7'd0);
    check("abort_we", ram_write_enable, 1'b0);
    repeat (4) @(negedge clk);
    check("abort_sb", exp_q.size(), 0);
    check("abort_done", done, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
